// File: rtl/fq_pkg.sv
// Shared fair-queue constants and types, used by the ingress buffer and the scheduler.
package fq_pkg;
  localparam int NUM_FLOWS = 8;
  localparam int DATA_W    = 64;
  localparam int FLOW_W    = $clog2(NUM_FLOWS);

  typedef logic [FLOW_W-1:0] flow_id_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/fq_flow_fifo.sv
// Single show-ahead FIFO: head word is visible combinationally whenever not empty.
module fq_flow_fifo
  import fq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = fq_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // One extra pointer bit separates full from empty when the index bits match.
  logic [PW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_wr, do_rd;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign level   = LW'(wr_q - rd_q);
  assign rd_data = mem_q[rd_q[PW-1:0]];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_wr) wr_d = wr_q + 1'b1;
    if (do_rd) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q[PW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/fq_flow_buffer.sv
// Ingress buffer: steers tagged words into per-flow show-ahead FIFOs for the scheduler.
module fq_flow_buffer
  import fq_pkg::*;
#(
  parameter int NUM_FLOWS    = fq_pkg::NUM_FLOWS,
  parameter int DATA_W       = fq_pkg::DATA_W,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 16,
  localparam int FW          = $clog2(NUM_FLOWS),
  localparam int LW          = $clog2(DEPTH+1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FW-1:0]                        in_flow,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic [NUM_FLOWS-1:0]                 fifo_rdreq,
  output logic [NUM_FLOWS-1:0]                 fifo_empty,
  output logic [NUM_FLOWS-1:0][DATA_W-1:0]     fifo_data,
  output logic [NUM_FLOWS-1:0]                 fifo_full,
  output logic [NUM_FLOWS-1:0][LW-1:0]         fifo_level,
  output logic [NUM_FLOWS-1:0][CNT_W-1:0]      drop_cnt
);
  // Ready depends only on registered full state, so there is no rdreq->ready path.
  assign in_ready = (DROP_ON_FULL != 0) ? 1'b1 : !fifo_full[in_flow];

  for (genvar i = 0; i < NUM_FLOWS; i++) begin : g_flow
    logic sel, wr_en;

    assign sel   = in_valid && (in_flow == FW'(i));
    assign wr_en = sel && !fifo_full[i];

    fq_flow_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (in_data),
      .rd_en   (fifo_rdreq[i]),
      .rd_data (fifo_data[i]),
      .empty   (fifo_empty[i]),
      .full    (fifo_full[i]),
      .level   (fifo_level[i])
    );

    if (DROP_ON_FULL != 0) begin : g_drop
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (sel && fifo_full[i] && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign drop_cnt[i] = cnt_q;
    end else begin : g_nodrop
      assign drop_cnt[i] = '0;
    end
  end
endmodule

// File: tb/tb_fq_flow_buffer.sv
// Directed bench: a backpressure instance (u0) and a drop-on-full instance (u1).
module tb_fq_flow_buffer;
  localparam int NF = 8;
  localparam int DW = 64;
  localparam int LW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              v0, rdy0, v1, rdy1;
  logic [2:0]        f0, f1;
  logic [DW-1:0]     d0, d1;
  logic [NF-1:0]     r0, r1, e0, e1, full0, full1;
  logic [NF-1:0][DW-1:0] q0, q1;
  logic [NF-1:0][LW-1:0] l0, l1;
  logic [NF-1:0][CW-1:0] c0, c1;

  fq_flow_buffer #(.DEPTH(16), .DROP_ON_FULL(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_flow(f0), .in_data(d0),
    .fifo_rdreq(r0), .fifo_empty(e0), .fifo_data(q0), .fifo_full(full0),
    .fifo_level(l0), .drop_cnt(c0));

  fq_flow_buffer #(.DEPTH(16), .DROP_ON_FULL(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_flow(f1), .in_data(d1),
    .fifo_rdreq(r1), .fifo_empty(e1), .fifo_data(q1), .fifo_full(full1),
    .fifo_level(l1), .drop_cnt(c1));

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] nxt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v0 = 0; f0 = 0; d0 = 0; r0 = 0;
    v1 = 0; f1 = 0; d1 = 0; r1 = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_empty", 64'(e0), 64'hFF);
    chk("rst_full",  64'(full0), 64'h0);
    chk("rst_level", 64'(l0), 64'h0);
    chk("rst_ready", 64'(rdy0), 64'h1);
    chk("rst_drop",  64'(c1), 64'h0);

    // Single write to flow 3, visible the cycle after the edge
    v0 = 1; f0 = 3; d0 = 64'hA5;
    step();
    v0 = 0;
    chk("w3_empty", 64'(e0), 64'hF7);
    chk("w3_data",  q0[3], 64'hA5);
    chk("w3_level", 64'(l0[3]), 64'd1);
    r0 = 8'h08;
    step();
    r0 = 0;
    chk("w3_pop_empty", 64'(e0), 64'hFF);

    // Fill flow 0
    for (int k = 0; k < 16; k++) begin
      v0 = 1; f0 = 0; d0 = 64'(100 + k);
      step();
    end
    v0 = 0;
    chk("fill_full",  64'(full0[0]), 64'h1);
    chk("fill_level", 64'(l0[0]), 64'd16);
    chk("fill_rdy_f0", 64'(rdy0), 64'h0);
    f0 = 1; #1;
    chk("fill_rdy_f1", 64'(rdy0), 64'h1);

    // 17th word is held while full
    v0 = 1; f0 = 0; d0 = 64'd116;
    step();
    chk("hold_level", 64'(l0[0]), 64'd16);
    chk("hold_rdy", 64'(rdy0), 64'h0);
    // Pop and write on a full flow: pop wins, write blocked
    r0 = 8'h01;
    step();
    r0 = 0;
    chk("popfull_level", 64'(l0[0]), 64'd15);
    chk("popfull_head",  q0[0], 64'd101);
    step();
    v0 = 0;
    chk("retry_level", 64'(l0[0]), 64'd16);

    // Drain flow 0: 101..116 in order
    r0 = 8'h01;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain0_%0d", k), q0[0], 64'(101 + k));
      step();
    end
    chk("drain0_empty", 64'(e0[0]), 64'h1);
    step();
    r0 = 0;
    chk("rd_empty_level", 64'(l0[0]), 64'd0);

    // Wrap on flow 7 at level 1..3
    nxt = 64'hC000;
    for (int k = 0; k < 2; k++) begin
      v0 = 1; f0 = 7; d0 = nxt; exp_q.push_back(nxt); nxt++;
      step();
    end
    for (int k = 0; k < 40; k++) begin
      v0 = ((k % 5) != 4);
      r0 = ((k % 5) != 2) ? 8'h80 : 8'h00;
      f0 = 7; d0 = nxt;
      if (r0[7]) begin
        chk($sformatf("wrap_head_%0d", k), q0[7], exp_q.pop_front());
      end
      if (v0) begin
        exp_q.push_back(nxt); nxt++;
      end
      step();
    end
    v0 = 0;
    chk("wrap_level", 64'(l0[7]), 64'(exp_q.size()));
    r0 = 8'h80;
    while (exp_q.size() > 0) begin
      chk("wrap_tail", q0[7], exp_q.pop_front());
      step();
    end
    step();
    r0 = 0;
    chk("wrap_end_level", 64'(l0[7]), 64'd0);
    chk("wrap_end_empty", 64'(e0), 64'hFF);

    // Drop mode: 20 words to flow 5
    for (int k = 0; k < 20; k++) begin
      v1 = 1; f1 = 5; d1 = 64'(200 + k);
      step();
    end
    v1 = 0;
    chk("drop_level", 64'(l1[5]), 64'd16);
    chk("drop_cnt",   64'(c1[5]), 64'd4);
    chk("drop_rdy",   64'(rdy1), 64'h1);
    chk("nodrop_cnt", 64'(c0), 64'h0);
    r1 = 8'h20;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drop_pop_%0d", k), q1[5], 64'(200 + k));
      step();
    end
    r1 = 0;
    chk("drop_drained", 64'(e1[5]), 64'h1);

    // Half-fill flows 2 and 4, then reset mid-operation
    for (int k = 0; k < 16; k++) begin
      v0 = 1; f0 = (k < 8) ? 3'd2 : 3'd4; d0 = 64'(k);
      v1 = 1; f1 = 3'd2; d1 = 64'(k);
      step();
    end
    v0 = 0; v1 = 0;
    chk("pre_rst_l2", 64'(l0[2]), 64'd8);
    chk("pre_rst_l4", 64'(l0[4]), 64'd8);
    chk("pre_rst_u1", 64'(full1[2]), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_empty0", 64'(e0), 64'hFF);
    chk("mid_rst_level0", 64'(l0), 64'h0);
    chk("mid_rst_empty1", 64'(e1), 64'hFF);
    chk("mid_rst_level1", 64'(l1), 64'h0);
    chk("mid_rst_drop",   64'(c1), 64'h0);
    chk("mid_rst_rdy",    64'(rdy0), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fq_flow_buffer.md
Name: fq_flow_buffer

Overview:
Ingress buffering stage directly upstream of the fair-queue scheduler. It takes a single tagged input word stream, steers each 64-bit word by flow ID into one of NUM_FLOWS per-flow show-ahead FIFOs, and exposes each FIFO's empty, data and read-request signals to the scheduler. Per-flow full, occupancy and drop-count status is exported for monitoring.

Parameters:
NUM_FLOWS, 8, number of flows/FIFOs (power of 2; FLOW_W = $clog2(NUM_FLOWS))
DATA_W, 64, word width
DEPTH, 16, entries per flow FIFO (power of 2, >= 2)
DROP_ON_FULL, 0, 0 = backpressure via in_ready; 1 = in_ready tied high, words to a full flow are dropped and counted
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready at posedge
in_flow  in  FLOW_W  destination flow of input word
in_data  in  DATA_W  input word
fifo_rdreq  in  1 x [NUM_FLOWS]  per-flow pop request from scheduler
fifo_empty  out  1 x [NUM_FLOWS]  per-flow empty
fifo_data  out  DATA_W x [NUM_FLOWS]  per-flow head word, valid when !fifo_empty[i]
fifo_full  out  1 x [NUM_FLOWS]  per-flow full
fifo_level  out  $clog2(DEPTH+1) x [NUM_FLOWS]  per-flow occupancy
drop_cnt  out  CNT_W x [NUM_FLOWS]  per-flow dropped-word count (DROP_ON_FULL=1 only, else 0)

Behaviour:
- Reset (rst high at posedge): all pointers 0; fifo_empty all 1; fifo_full all 0; fifo_level all 0; drop_cnt all 0. in_ready = 1 after reset (nothing full). Storage is not reset; fifo_data is don't-care while empty. Reset mid-operation discards all buffered words and counts immediately.
- in_ready (DROP_ON_FULL=0): combinational = !fifo_full[in_flow]; depends only on registered full, never on fifo_rdreq (no rdreq->ready path). in_ready may be observed with in_valid low.
- in_ready (DROP_ON_FULL=1): constant 1. Word with in_valid && fifo_full[in_flow] is discarded; drop_cnt[in_flow] += 1, saturating at 2^CNT_W-1.
- Write: accepted word stored at wr_ptr[in_flow]; level +1. Exactly one flow can be written per cycle.
- Read: show-ahead. fifo_data[i] = mem[i][rd_ptr[i]] combinationally. fifo_rdreq[i] && !fifo_empty[i] at posedge pops the head; level -1. fifo_rdreq[i] while empty is ignored (no pointer or level change, no error flag).
- Latency: word accepted at edge N: fifo_empty cleared and fifo_data valid in the cycle after edge N. No write-to-read bypass when empty.
- Simultaneous pop and write to the same non-full flow: both take effect; level unchanged; empty/full unchanged. Empty flow with write+rdreq: rdreq ignored, write occurs, level becomes 1.
- Full flow with pop and write in the same cycle: write is blocked (DROP_ON_FULL=0) or dropped and counted (=1); pop occurs; level becomes DEPTH-1.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. empty = (wr==rd); full = MSBs differ and the rest equal. level = wr-rd, width $clog2(DEPTH+1).
- Independent flows are fully concurrent: any subset of fifo_rdreq may be asserted in the same cycle.

Decomposition:
- fq_pkg: NUM_FLOWS, DATA_W, FLOW_W constants; flow_id_t (logic [FLOW_W-1:0]); data_t (logic [DATA_W-1:0]). Shared with the scheduler.
- Sub-module fq_flow_fifo: single show-ahead FIFO (wr_en, wr_data, rd_en, rd_data, empty, full, level) parameterised on DEPTH/DATA_W. Instantiate NUM_FLOWS times via generate. Top holds the flow demux, in_ready mux and drop counters.

Test Plan:
- Reset then write flow 3 data 64'hA5 at edge N -> fifo_empty[3]=0 in cycle N+1, fifo_data[3]=64'hA5, level[3]=1; all other flows stay empty.
- Write 16 words to flow 0 (DROP_ON_FULL=0) -> fifo_full[0]=1, level=16, in_ready=0 with in_flow=0 and 1 with in_flow=1; 17th word is held, not lost.
- Full flow 0, rdreq[0] and in_valid to flow 0 in the same cycle -> pop occurs, write blocked, level=15; the next cycle the write is accepted, level=16.
- DROP_ON_FULL=1: 20 words to flow 5, DEPTH=16 -> level=16, drop_cnt[5]=4; popping yields the first 16 words in order.
- Wrap: 40 interleaved write/pop cycles on flow 7 at level 1-3 -> FIFO order is preserved across pointer wrap; rdreq on an empty flow leaves level at 0.
- Reset asserted with flows 2 and 4 half full and drop_cnt nonzero -> the next cycle all empty=1, level=0, drop_cnt=0, in_ready=1.
